// File: rtl/oscilo_pkg.sv
// oscilo_pkg
// Shared definitions for the oscilloscope capture/readout path.
//   DEFAULT_SAMPLE_DEPTH : default log2 of the sample memory depth
//   HDR_BYTE0/HDR_BYTE1  : stream header bytes sent before the samples
//                          when CAPTURE_READOUT_HEADER_EN is defined
//   readout_state_t      : readout FSM state encoding
package oscilo_pkg;

  localparam int DEFAULT_SAMPLE_DEPTH = 8;

  localparam logic [7:0] HDR_BYTE0 = 8'hA5;
  localparam logic [7:0] HDR_BYTE1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_READ = 3'd3,
    ST_LOAD = 3'd4,
    ST_SEND = 3'd5,
    ST_DONE = 3'd6
  } readout_state_t;

endpackage

// File: rtl/readout_addr_gen.sv
// readout_addr_gen
// Read address and sample counter for the readout stage. The oldest sample
// of the circular buffer sits half a buffer after the trigger address, so
// the readout starts there and walks forward with wrap-around.
// Ports:
//   clk_50mhz   in  system clock
//   reset       in  synchronous active-high reset
//   load        in  start accepted: latch start address, clear count
//   advance     in  one sample byte transferred: step address and count
//   offset      in  trigger address from the capture stage
//   rd_addr     out current read address
//   last_sample out the sample in flight is the final one of the readout
module readout_addr_gen
  import oscilo_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    advance,
  input  logic [SAMPLE_DEPTH-1:0] offset,
  output logic [SAMPLE_DEPTH-1:0] rd_addr,
  output logic                    last_sample
);

  localparam logic [SAMPLE_DEPTH-1:0] HALF_DEPTH = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
  localparam logic [SAMPLE_DEPTH-1:0] ADDR_ONE   = {{(SAMPLE_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_DEPTH:0]   CNT_ONE    = {{SAMPLE_DEPTH{1'b0}}, 1'b1};
  localparam logic [SAMPLE_DEPTH:0]   CNT_LAST   = {1'b0, {SAMPLE_DEPTH{1'b1}}};

  logic [SAMPLE_DEPTH:0] cnt;

  // Address and count registers. The address add is naturally modulo the
  // buffer size because of the register width.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      rd_addr <= '0;
      cnt     <= '0;
    end else if (load) begin
      rd_addr <= offset + HALF_DEPTH;
      cnt     <= '0;
    end else if (advance) begin
      rd_addr <= rd_addr + ADDR_ONE;
      cnt     <= cnt + CNT_ONE;
    end
  end

  // The count still holds the index of the byte being sent, so the final
  // byte is the one seen while the count equals depth-1.
  assign last_sample = (cnt == CNT_LAST);

endmodule

// File: rtl/capture_readout.sv
// capture_readout
// Reads the circular sample memory back oldest-first after a capture and
// streams the samples as bytes over a valid/ready link.
// Optional: define CAPTURE_READOUT_HEADER_EN to prefix the stream with the
// two header bytes HDR_BYTE0, HDR_BYTE1.
// Ports:
//   clk_50mhz in  system clock
//   reset     in  synchronous active-high reset
//   start     in  level request, sampled in IDLE
//   offset    in  trigger address, latched on the start cycle
//   busy      out readout in progress
//   done      out readout finished, held until start drops
//   mem_re    out memory read enable pulse
//   mem_addr  out memory read address
//   mem_data  in  read data, one cycle after mem_re
//   tx_data   out output byte
//   tx_valid  out output byte valid
//   tx_ready  in  consumer ready
module capture_readout
  import oscilo_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] offset,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_re,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  input  logic [7:0]              mem_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  readout_state_t state, next_state;

  logic [SAMPLE_DEPTH-1:0] rd_addr;
  logic [SAMPLE_DEPTH-1:0] last_addr;
  logic                    last_sample;
  logic                    load_addr;
  logic                    advance;
  logic                    load_sample;
  logic                    clear_valid;
`ifdef CAPTURE_READOUT_HEADER_EN
  logic                    load_hdr;
  logic [7:0]              hdr_byte;
`endif

  readout_addr_gen #(
    .SAMPLE_DEPTH(SAMPLE_DEPTH)
  ) u_addr_gen (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .load       (load_addr),
    .advance    (advance),
    .offset     (offset),
    .rd_addr    (rd_addr),
    .last_sample(last_sample)
  );

  // State register; reset wins from any state.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. Header states load their byte on the
  // entry cycle (tx_valid still low) and then wait for the handshake.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_re      = 1'b0;
    load_addr   = 1'b0;
    advance     = 1'b0;
    load_sample = 1'b0;
    clear_valid = 1'b0;
`ifdef CAPTURE_READOUT_HEADER_EN
    load_hdr    = 1'b0;
    hdr_byte    = HDR_BYTE0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_addr  = 1'b1;
`ifdef CAPTURE_READOUT_HEADER_EN
          next_state = ST_HDR0;
`else
          next_state = ST_READ;
`endif
        end
      end
`ifdef CAPTURE_READOUT_HEADER_EN
      ST_HDR0: begin
        busy = 1'b1;
        if (!tx_valid) begin
          load_hdr = 1'b1;
          hdr_byte = HDR_BYTE0;
        end else if (tx_ready) begin
          clear_valid = 1'b1;
          next_state  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        busy = 1'b1;
        if (!tx_valid) begin
          load_hdr = 1'b1;
          hdr_byte = HDR_BYTE1;
        end else if (tx_ready) begin
          clear_valid = 1'b1;
          next_state  = ST_READ;
        end
      end
`endif
      ST_READ: begin
        busy       = 1'b1;
        mem_re     = 1'b1;
        next_state = ST_LOAD;
      end
      ST_LOAD: begin
        busy        = 1'b1;
        load_sample = 1'b1;
        next_state  = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        if (tx_ready) begin
          clear_valid = 1'b1;
          advance     = 1'b1;
          next_state  = last_sample ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!start) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output holding register and last read address. The address is only
  // driven fresh during the read pulse and otherwise holds its last value.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      last_addr <= '0;
    end else begin
      if (mem_re) begin
        last_addr <= rd_addr;
      end
      if (load_sample) begin
        tx_data  <= mem_data;
        tx_valid <= 1'b1;
`ifdef CAPTURE_READOUT_HEADER_EN
      end else if (load_hdr) begin
        tx_data  <= hdr_byte;
        tx_valid <= 1'b1;
`endif
      end else if (clear_valid) begin
        tx_valid <= 1'b0;
      end
    end
  end

  assign mem_addr = mem_re ? rd_addr : last_addr;

endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout
// Self-checking bench for capture_readout: a memory model, a scoreboard of
// expected stream bytes, a vector table of readout scenarios and
// hand-written sequences for reset abort and held start.
module tb_capture_readout;

`ifdef CAPTURE_READOUT_HEADER_EN
  localparam int HDR_N     = 2;
  localparam int FIRST_LAT = 2;
`else
  localparam int HDR_N     = 0;
  localparam int FIRST_LAT = 3;
`endif
  localparam int NSAMP    = 256;
  localparam int TOTAL    = NSAMP + HDR_N;
  localparam int TRIG_IDX = HDR_N + 128;
  localparam int TIMEOUT  = 6000;

  logic       clk_50mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic [7:0] offset    = 8'h00;
  logic       busy, done, mem_re, tx_valid;
  logic [7:0] mem_addr, tx_data;
  logic [7:0] mem_data  = 8'h00;
  logic       tx_ready  = 1'b1;

  logic [7:0] mem [0:255];
  logic [7:0] exp_q [$];
  logic [7:0] cap [0:TOTAL-1];

  int  check_count = 0;
  int  pass_count  = 0;
  int  cyc = 0;
  int  xfer_count = 0;
  int  mem_re_count = 0;
  int  first_valid_cyc = -1;
  int  last_xfer_cyc = 0;
  int  start_cyc = 0;
  int  done_cyc = 0;
  int  hold_cnt = 0;
  bit  bp_en = 1'b0;
  bit  force_low = 1'b0;
  bit  ignore_stall = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [7:0] off;
    logic [7:0] key;
    bit         bp;
    logic [7:0] exp_first;
    logic [7:0] exp_trig;
  } vec_t;

  vec_t vecs [4];

  capture_readout #(.SAMPLE_DEPTH(8)) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .start    (start),
    .offset   (offset),
    .busy     (busy),
    .done     (done),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Synchronous memory: data appears one cycle after the read enable.
  always @(posedge clk_50mhz) begin
    cyc <= cyc + 1;
    if (mem_re) mem_data <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      pass_count++;
  endtask

  // Link-side monitor: picks tx_ready for the coming edge, then checks the
  // stall rules and scores every handshake against the expected queue.
  always @(negedge clk_50mhz) begin
    if (bp_en) begin
      if (hold_cnt > 0) begin
        tx_ready = 1'b0;
        hold_cnt--;
      end else begin
        tx_ready = 1'b1;
        hold_cnt = $urandom_range(0, 10);
      end
    end else begin
      tx_ready = 1'b1;
    end
    if (force_low) tx_ready = 1'b0;

    if (reset || ignore_stall) begin
      prev_stall = 1'b0;
    end else if (prev_stall) begin
      checkOutput("stall_valid", 32'(tx_valid), 32'd1);
      checkOutput("stall_data", 32'(tx_data), 32'(prev_data));
    end

    if (mem_re) mem_re_count++;
    if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (tx_valid && tx_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        checkOutput("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (xfer_count < TOTAL) cap[xfer_count] = tx_data;
      xfer_count++;
      last_xfer_cyc = cyc;
    end
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_data  = tx_data;
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_done"},     32'(done),     32'd0);
    checkOutput({tag, "_mem_re"},   32'(mem_re),   32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    checkOutput({tag, "_tx_data"},  32'(tx_data),  32'd0);
  endtask

  // Fill memory, queue the expected stream and request a readout.
  task automatic applyStimulus(input logic [7:0] off, input logic [7:0] key,
                               input bit bp, input bit hold_start);
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ key;
    exp_q.delete();
`ifdef CAPTURE_READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`endif
    for (int k = 0; k < NSAMP; k++) begin
      a = off + 8'h80 + 8'(k);
      exp_q.push_back(mem[a]);
    end
    bp_en = bp;
    hold_cnt = 0;
    xfer_count = 0;
    mem_re_count = 0;
    first_valid_cyc = -1;
    @(negedge clk_50mhz);
    start = 1'b1;
    offset = off;
    start_cyc = cyc;
    @(negedge clk_50mhz);
    if (!hold_start) start = 1'b0;
    offset = ~off;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < TIMEOUT; t++) begin
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk_50mhz);
    end
    if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkRun(input string tag, input logic [7:0] exp_first,
                          input logic [7:0] exp_trig);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_byte_count"}, 32'(xfer_count), 32'(TOTAL));
    checkOutput({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_mem_re_count"}, 32'(mem_re_count), 32'(NSAMP));
    checkOutput({tag, "_first_valid_lat"}, 32'(first_valid_cyc - start_cyc), 32'(FIRST_LAT));
    checkOutput({tag, "_done_lat"}, 32'(done_cyc - last_xfer_cyc), 32'd1);
    checkOutput({tag, "_first_sample"}, 32'(cap[HDR_N]), 32'(exp_first));
    checkOutput({tag, "_trigger_byte"}, 32'(cap[TRIG_IDX]), 32'(exp_trig));
`ifdef CAPTURE_READOUT_HEADER_EN
    checkOutput({tag, "_hdr0"}, 32'(cap[0]), 32'hA5);
    checkOutput({tag, "_hdr1"}, 32'(cap[1]), 32'h5A);
`endif
  endtask

  initial begin
    bit ok;
    int re_snapshot;

    //          offset key    bp    first  trigger
    vecs[0] = '{8'h10, 8'h00, 1'b0, 8'h90, 8'h10};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 8'h7F, 8'hFF};
    vecs[2] = '{8'h37, 8'hA3, 1'b1, 8'h14, 8'h94};
    vecs[3] = '{8'h00, 8'h5C, 1'b1, 8'hDC, 8'h5C};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk_50mhz);
    checkResetOutputs("reset");
    reset = 1'b0;

    $display("[TB] vector table readouts");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].off, vecs[v].key, vecs[v].bp, 1'b0);
      waitDone(ok);
      checkRun($sformatf("vec%0d", v), vecs[v].exp_first, vecs[v].exp_trig);
      @(negedge clk_50mhz);
      checkOutput($sformatf("vec%0d_idle_after_done", v), 32'(done), 32'd0);
    end

    $display("[TB] reset during byte 50");
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0);
    for (int t = 0; t < TIMEOUT && xfer_count < 50; t++) @(negedge clk_50mhz);
    force_low = 1'b1;
    @(negedge clk_50mhz);
    for (int t = 0; t < 20 && !tx_valid; t++) @(negedge clk_50mhz);
    checkOutput("abort_in_send", 32'(tx_valid), 32'd1);
    ignore_stall = 1'b1;
    reset = 1'b1;
    @(negedge clk_50mhz);
    checkResetOutputs("abort");
    reset = 1'b0;
    force_low = 1'b0;
    @(negedge clk_50mhz);
    ignore_stall = 1'b0;
    applyStimulus(8'h44, 8'h00, 1'b0, 1'b0);
    waitDone(ok);
    checkRun("after_abort", 8'hC4, 8'h44);
    @(negedge clk_50mhz);

    $display("[TB] start held through completion");
    applyStimulus(8'h80, 8'h0F, 1'b0, 1'b1);
    waitDone(ok);
    checkRun("hold1", 8'h0F, 8'h8F);
    re_snapshot = mem_re_count;
    repeat (5) @(negedge clk_50mhz);
    checkOutput("hold_done_stays", 32'(done), 32'd1);
    checkOutput("hold_no_restart", 32'(mem_re_count), 32'(re_snapshot));
    start = 1'b0;
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
    checkOutput("hold_idle_done", 32'(done), 32'd0);
    checkOutput("hold_idle_busy", 32'(busy), 32'd0);
    applyStimulus(8'h80, 8'h0F, 1'b0, 1'b0);
    waitDone(ok);
    checkRun("hold2", 8'h0F, 8'h8F);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/capture_readout.md
# capture_readout

Downstream stage of the capture path. After a capture completes, it reads the circular sample memory back in chronological order, oldest sample first, starting from the trigger offset. It streams the samples as bytes over a valid/ready interface to the host link, such as a UART transmitter. It owns the memory read port while busy and signals completion with a level `done`, using the same start/done convention as the capture stage.

## Interface

Parameters:
- `SAMPLE_DEPTH`, default 8: log2 of the sample count (256 samples).

Ports:
- `clk_50mhz`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE; 1 begins a readout.
- `offset`  in  SAMPLE_DEPTH  trigger address produced by the capture stage; latched on the start cycle.
- `busy`  out  1  high from the cycle after start is accepted until DONE is entered.
- `done`  out  1  high in DONE; held until `start` is low.
- `mem_re`  out  1  memory read enable, one-cycle pulse per sample.
- `mem_addr`  out  SAMPLE_DEPTH  memory read address.
- `mem_data`  in  8  read data, valid exactly one cycle after the `mem_re` cycle.
- `tx_data`  out  8  output byte.
- `tx_valid`  out  1  output byte valid.
- `tx_ready`  in  1  consumer accepts the byte when `tx_valid && tx_ready`.

## Operation

- States: IDLE, HDR0, HDR1, READ, LOAD, SEND, DONE.
- **IDLE**
  - `start`=1 latches `rd_addr = offset + 2^(SAMPLE_DEPTH-1)` (mod 2^SAMPLE_DEPTH) and clears `cnt` (width SAMPLE_DEPTH+1).
  - Next state is HDR0 if the header is compiled in, else READ.
- **READ**: drive `mem_re`=1 and `mem_addr=rd_addr`, then go to LOAD.
- **LOAD**: register `mem_data` into `tx_data`, set `tx_valid`=1, go to SEND.
- **SEND**: hold `tx_data`/`tx_valid` stable until `tx_ready`. On the transfer:
  - clear `tx_valid`;
  - `rd_addr += 1`, wrapping modulo 2^SAMPLE_DEPTH;
  - `cnt += 1`;
  - if `cnt` was 2^SAMPLE_DEPTH-1, go to DONE, else go to READ.
- **DONE**: `done`=1, `busy`=0. Go to IDLE when `start`=0.
- Output order: exactly 2^SAMPLE_DEPTH sample bytes. The trigger sample (address `offset`) is output sample index 2^(SAMPLE_DEPTH-1), i.e. index 128 at default depth.
- `offset` changes after the start cycle are ignored.
- `start` deasserting mid-readout is ignored; the readout runs to completion.
- `mem_re` is never asserted outside READ. `mem_addr` holds its last value otherwise.
- Any undefined state goes to IDLE.

## Timing

- Reset values: `busy`=0, `done`=0, `mem_re`=0, `mem_addr`=0, `tx_valid`=0, `tx_data`=0, state IDLE, `cnt`=0.
- Reset has priority in any state. A mid-readout reset aborts immediately; no further `mem_re` or `tx_valid` in the following cycle.
- Start cycle = cycle 0. Without the header: `mem_re` in cycle 1, first `tx_valid` in cycle 3.
- With `tx_ready` tied high, one byte every 3 cycles. A full readout takes 3·2^SAMPLE_DEPTH cycles from READ to DONE.
- `tx_valid` never drops without a transfer, and `tx_data` never changes while `tx_valid && !tx_ready`.
- `done` rises in the cycle after the last transfer.
- If `start` is still high when DONE is entered, the block stays in DONE and does not restart until `start` has been low for at least one cycle.

## Configuration

- Macro: `CAPTURE_READOUT_HEADER_EN`.
- **Defined**:
  - HDR0 sends 0xA5, then HDR1 sends 0x5A, then the block goes to READ. Each header byte uses SEND handshake rules and is valid from the cycle after entry.
  - Total bytes = 2 + 2^SAMPLE_DEPTH.
  - The trigger sample is stream byte index 2 + 2^(SAMPLE_DEPTH-1).
- **Undefined**: HDR0/HDR1 are unreachable and removed; only sample bytes are sent.

## Structure

- Shared package `oscilo_pkg` holds:
  - `SAMPLE_DEPTH` default constant;
  - state enum `readout_state_t`;
  - header constants `HDR_BYTE0`=8'hA5 and `HDR_BYTE1`=8'h5A.
- Sub-module `readout_addr_gen` holds the start-address computation, wrapping increment and `cnt`, with a last-sample flag output.
- The FSM and output holding register stay in the top level.

## Test plan

- Memory holds `mem[i]=i`, `offset`=0x10, `tx_ready`=1, header off, `start` pulsed → 256 bytes 0x90, 0x91 … 0xFF, 0x00 … 0x8F; byte 128 = 0x10; `done` one cycle after the last byte.
- `offset`=0xFF → first byte 0x7F, wrap 0xFF→0x00 between bytes 128 and 129; `mem_addr` never exceeds 0xFF.
- Random `tx_ready` backpressure, ready held low for 0–10 cycles → `tx_data` stable while stalled; no byte lost or duplicated; exactly one `mem_re` per byte.
- Reset asserted while in SEND at byte 50 → next cycle all outputs at reset values; a new `start` reads from the new `offset`, first byte correct.
- `start` held high through completion → `done` stays 1 with no restart; `start` low → IDLE next cycle; `start` high again → second readout identical.
- `CAPTURE_READOUT_HEADER_EN` defined → stream begins 0xA5, 0x5A; 258 bytes total; trigger byte at index 130.
